// File: rtl/vga_line_fetch.sv
// Line fetcher for the VGA driver: copies 320-pixel framebuffer rows into a
// ping-pong pair of line buffers and serves them 2x2-upscaled, zero latency.
module vga_line_fetch #(
    parameter int unsigned FB_W   = 320,
    parameter int unsigned FB_H   = 240,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        next_x,
    input  logic [9:0]        next_y,
    input  logic              active,
    output logic [7:0]        color_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned COL_W = $clog2(FB_W);
    localparam int unsigned ROW_W = $clog2(FB_H);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              start_q, start_d;
    logic              active_dly_q, active_dly_d;
    logic [9:0]        y_dly_q, y_dly_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        valid_q, valid_d;
    logic              underrun_q, underrun_d;

    logic [7:0] line_buf0 [FB_W];
    logic [7:0] line_buf1 [FB_W];

    logic             line_end;
    logic             trigger;
    logic [8:0]       disp_row;
    logic [ROW_W-1:0] target_row;
    logic             bank_sel;
    logic [COL_W-1:0] pix_idx;
    logic             unused_x0;

    assign unused_x0 = next_x[0];

    // Only the end of a row's first display line triggers; the fetch then
    // overlaps the row's second line, which reads the other bank.
    always_comb begin
        line_end   = active_dly_q & ~active;
        trigger    = line_end & ~y_dly_q[0];
        disp_row   = y_dly_q[9:1];
        target_row = (disp_row >= 9'(FB_H - 1)) ? '0 : ROW_W'(disp_row + 9'd1);
    end

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        active_dly_d = active;
        y_dly_d      = active ? next_y : y_dly_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        underrun_d   = underrun_q;

        case (state_q)
            IDLE: begin
                // start_q stands in for a trigger so row 0 loads right after reset.
                if (start_q || trigger) begin
                    row_d            = start_q ? '0 : target_row;
                    addr_d           = ADDR_W'(row_d) * ADDR_W'(FB_W);
                    col_d            = '0;
                    valid_d[row_d[0]] = 1'b0;
                    start_d          = 1'b0;
                    state_d          = FETCH;
                end
            end
            FETCH: begin
                if (trigger) begin
                    underrun_d = 1'b1;
                end
                if (mem_ack) begin
                    if (col_q == COL_W'(FB_W - 1)) begin
                        col_d             = '0;
                        valid_d[row_q[0]] = 1'b1;
                        state_d           = IDLE;
                    end else begin
                        col_d  = col_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b1;
            active_dly_q <= 1'b0;
            y_dly_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            addr_q       <= '0;
            valid_q      <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            active_dly_q <= active_dly_d;
            y_dly_q      <= y_dly_d;
            row_q        <= row_d;
            col_q        <= col_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            underrun_q   <= underrun_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state_q == FETCH && mem_ack) begin
            if (row_q[0]) begin
                line_buf1[col_q] <= mem_data;
            end else begin
                line_buf0[col_q] <= mem_data;
            end
        end
    end

    always_comb begin
        bank_sel = next_y[1];
        pix_idx  = next_x[9:1];
        if (valid_q[bank_sel]) begin
            color_out = bank_sel ? line_buf1[pix_idx] : line_buf0[pix_idx];
        end else begin
            color_out = 8'h00;
        end
    end

    assign mem_req  = (state_q == FETCH);
    assign busy     = (state_q == FETCH);
    assign mem_addr = addr_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomized bench for vga_line_fetch: a row-level model predicts every output
// each cycle, plus literal checkpoints for reset, frame wrap, underrun and abort.
module tb_vga_line_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  next_x = '0;
    logic [9:0]  next_y = '0;
    logic        active = 1'b0;
    logic [7:0]  color_out;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = '0;
    logic        busy;
    logic        underrun;

    vga_line_fetch #(.FB_W(320), .FB_H(240), .ADDR_W(17)) dut (
        .clock     (clock),
        .reset     (reset),
        .next_x    (next_x),
        .next_y    (next_y),
        .active    (active),
        .color_out (color_out),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fb [76800];

    // Row-level model: which row each bank holds, and the row job in flight.
    bit m_known = 0;
    bit m_valid [2];
    int m_brow  [2];
    bit m_job   = 0;
    int m_row   = 0;
    int m_done  = 0;
    int m_held  = 0;
    bit m_under = 0;
    bit m_start = 0;
    bit m_pact  = 0;
    int m_ylast = 0;

    int ack_mode = 0;   // 0 never, 1 always, 2 every other cycle, 3 random 75%
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit rst, input bit act, input int x, input int y);
        bit ack;
        int exp_addr;
        int yb;
        int target;
        bit trig;
        logic [7:0] exp_color;
        @(negedge clock);
        reset  = rst;
        active = act;
        next_x = 10'(x);
        next_y = 10'(y);
        case (ack_mode)
            0:       ack = 1'b0;
            1:       ack = 1'b1;
            2:       ack = cyc[0];
            default: ack = ($urandom_range(0, 3) != 0);
        endcase
        cyc++;
        mem_ack  = ack;
        exp_addr = m_job ? m_row * 320 + m_done : m_held;
        mem_data = m_job ? fb[exp_addr] : 8'($urandom);
        #1;
        if (m_known) begin
            yb = (y >> 1) & 1;
            exp_color = m_valid[yb] ? fb[m_brow[yb] * 320 + x / 2] : 8'h00;
            chk("color_out", 32'(color_out), 32'(exp_color));
            chk("mem_req", 32'(mem_req), 32'(m_job));
            chk("busy", 32'(busy), 32'(m_job));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("underrun", 32'(underrun), 32'(m_under));
        end
        @(posedge clock);
        if (rst) begin
            m_known    = 1;
            m_valid[0] = 0;
            m_valid[1] = 0;
            m_job      = 0;
            m_held     = 0;
            m_under    = 0;
            m_start    = 1;
            m_pact     = 0;
            m_ylast    = 0;
        end else begin
            trig   = m_pact && !act && (m_ylast % 2 == 0);
            target = (m_ylast / 2 == 239) ? 0 : m_ylast / 2 + 1;
            if (m_job) begin
                if (trig) m_under = 1;
                if (ack) begin
                    m_done++;
                    if (m_done == 320) begin
                        m_job = 0;
                        m_valid[m_row % 2] = 1;
                        m_brow[m_row % 2]  = m_row;
                        m_held = m_row * 320 + 319;
                    end
                end
            end else if (m_start || trig) begin
                m_row   = m_start ? 0 : target;
                m_start = 0;
                m_job   = 1;
                m_done  = 0;
                m_valid[m_row % 2] = 0;
            end
            m_pact = act;
            if (act) m_ylast = y;
        end
    endtask

    task automatic run_line(input int y, input int npix, input int nblank);
        for (int i = 0; i < npix; i++) tick(0, 1, i, y);
        for (int i = 0; i < nblank; i++) begin
            tick(0, 0, 0, 0);
            if (i == 0 && y == 478) begin
                #1;
                chk("wrap_fetch_addr", 32'(mem_addr), 32'd0);
                chk("wrap_fetch_busy", 32'(busy), 32'd1);
            end
        end
    endtask

    task automatic probe(input string name, input int x, input int y, input logic [7:0] exp);
        #1;
        active = 1'b0;
        next_x = 10'(x);
        next_y = 10'(y);
        #1;
        chk(name, 32'(color_out), 32'(exp));
    endtask

    initial begin
        int px;
        for (int i = 0; i < 76800; i++) fb[i] = 8'($urandom);

        // Reset then row 0 with back-to-back acks.
        ack_mode = 1;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        #1;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        for (int k = 1; k <= 321; k++) begin
            tick(0, 0, $urandom_range(0, 639), $urandom_range(0, 3));
            if (k == 1) begin
                #1;
                chk("first_addr", 32'(mem_addr), 32'd0);
                chk("first_busy", 32'(busy), 32'd1);
            end
            if (k == 320) begin
                #1;
                chk("last_addr", 32'(mem_addr), 32'd319);
                chk("busy_at_320", 32'(busy), 32'd1);
            end
            if (k == 321) begin
                #1;
                chk("busy_drop_321", 32'(busy), 32'd0);
            end
        end
        probe("row0_word1", 2, 0, fb[1]);

        // Display lines: start of frame, then the frame wrap and next frame start.
        ack_mode = 2;
        for (int y = 0; y < 8; y++) begin
            run_line(y, 640, 40);
            if (y == 2) probe("line2_row1", 200, 2, fb[320 + 100]);
        end
        ack_mode = 3;
        for (int y = 472; y < 480; y++) run_line(y, 640, 40);
        probe("last_pixel", 639, 479, fb[76799]);
        for (int y = 0; y < 4; y++) run_line(y, 640, 40);
        #1;
        chk("no_underrun_frame", 32'(underrun), 32'd0);

        // Memory stalled across two triggers.
        ack_mode = 0;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        run_line(0, 10, 5);
        run_line(2, 10, 5);
        #1;
        chk("stall_underrun", 32'(underrun), 32'd1);
        chk("stall_addr", 32'(mem_addr), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        probe("stall_color", 10, 0, 8'h00);

        // Reset in the middle of a row fetch.
        ack_mode = 1;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int k = 1; k <= 101; k++) tick(0, 0, $urandom_range(0, 639), $urandom_range(0, 3));
        #1;
        chk("abort_col100_addr", 32'(mem_addr), 32'd100);
        tick(1, 0, 0, 0);
        #1;
        chk("abort_req_drop", 32'(mem_req), 32'd0);
        probe("abort_bank0_invalid", 40, 0, 8'h00);
        probe("abort_bank1_invalid", 40, 2, 8'h00);
        tick(0, 0, 0, 0);
        #1;
        chk("restart_addr", 32'(mem_addr), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 330; k++) tick(0, 0, $urandom_range(0, 639), $urandom_range(0, 3));
        px = $urandom_range(0, 639);
        probe("restart_row0", px, 1, fb[px / 2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
